// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM states, default array geometry, drain length and address widths
package systolic_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_LOAD, ST_STREAM, ST_DRAIN, ST_DONE} state_e;
  localparam int N_DEF = 4;
  localparam int MULT_LAT_DEF = 2;
  localparam int LEN_W_DEF = 16;
  function automatic int drain_cyc(input int n, input int mult_lat);
    return mult_lat + 2 * (n - 1) + 1;
  endfunction
  localparam int DRAIN_CYC = drain_cyc(N_DEF, MULT_LAT_DEF);
  localparam int WADDR_W = $clog2(N_DEF);
endpackage

// File: rtl/systolic_phase_cnt.sv
// systolic_phase_cnt: loadable down-counter with terminal-count flag
//   iClk, iRst : clock, sync active-high reset
//   iLoad/iVal : load iVal this cycle (wins over counting)
//   oTc        : count has reached zero; counter then holds
module systolic_phase_cnt #(
  parameter int W = 17
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iLoad,
  input  logic [W-1:0] iVal,
  output logic         oTc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign oTc = cnt_q == '0;
  always_comb cnt_d = iLoad ? iVal : oTc ? cnt_q : cnt_q - 1'b1;
  always_ff @(posedge iClk) cnt_q <= iRst ? '0 : cnt_d;
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for an N x N systolic array (clear, load weights, stream, drain, capture)
//   iStart/iAbort/iLen   : job request, abandon, vector count (latched on accept)
//   oBusy/oDone          : job active, completion pulse
//   oClearAcc            : accumulator clear into row 0
//   oWeightLoad/Addr     : weight shift enable and row index
//   oDataRd/Addr         : data buffer read enable and vector index
//   oCapture             : accumulators final, latch results
//   oBusyCycles          : busy cycles of the current job, only with SYSTOLIC_CTRL_PERF_EN
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic                 iAbort,
  input  logic [LEN_W-1:0]     iLen,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oClearAcc,
  output logic                 oWeightLoad,
  output logic [$clog2(N)-1:0] oWeightAddr,
  output logic                 oDataRd,
  output logic [LEN_W-1:0]     oDataAddr,
  output logic                 oCapture
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]          oBusyCycles
`endif
);
  localparam int AW = $clog2(N);
  localparam int CW = LEN_W + 1;
  localparam int D = drain_cyc(N, MULT_LAT);
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, da_q, da_d;
  logic [AW-1:0] wa_q, wa_d;
  logic busy_q, busy_d, done_q, done_d, cap_q, cap_d, clr_q, clr_d, wl_q, wl_d, rd_q, rd_d;
  logic accept, ld, tc;
  logic [CW-1:0] ld_val;
  systolic_phase_cnt #(.W(CW)) u_cnt (.iClk(iClk), .iRst(iRst), .iLoad(ld), .iVal(ld_val), .oTc(tc));
  // Outputs are registered from the next state, so each phase is visible in the cycle it is entered.
  // DRAIN holds D-1 cycles: the DONE/capture cycle is the last cycle of the drain window.
  always_comb begin
    accept = state_q == ST_IDLE && iStart && !iAbort;
    len_d = accept ? iLen : len_q;
    state_d = state_q;
    ld = 1'b0;
    ld_val = '0;
    case (state_q)
      ST_IDLE: state_d = accept ? (iLen == '0 ? ST_DONE : ST_CLEAR) : ST_IDLE;
      ST_CLEAR: begin
        state_d = ST_LOAD;
        ld = 1'b1;
        ld_val = CW'(N - 1);
      end
      ST_LOAD: if (tc) begin
        state_d = ST_STREAM;
        ld = 1'b1;
        ld_val = {1'b0, len_q} - 1'b1;
      end
      ST_STREAM: if (tc) begin
        state_d = ST_DRAIN;
        ld = 1'b1;
        ld_val = CW'(D - 2);
      end
      ST_DRAIN: state_d = tc ? ST_DONE : ST_DRAIN;
      default: state_d = ST_IDLE;
    endcase
    if (iAbort) state_d = ST_IDLE;
    wa_d = (state_d == ST_LOAD && state_q == ST_LOAD) ? wa_q + 1'b1 : '0;
    da_d = (state_d == ST_STREAM && state_q == ST_STREAM) ? da_q + 1'b1 : '0;
    busy_d = state_d != ST_IDLE;
    done_d = state_d == ST_DONE;
    cap_d = done_d && len_d != '0;
    clr_d = state_d == ST_CLEAR;
    wl_d = state_d == ST_LOAD;
    rd_d = state_d == ST_STREAM;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      len_q <= '0;
      wa_q <= '0;
      da_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cap_q <= 1'b0;
      clr_q <= 1'b0;
      wl_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      wa_q <= wa_d;
      da_q <= da_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cap_q <= cap_d;
      clr_q <= clr_d;
      wl_q <= wl_d;
      rd_q <= rd_d;
    end
  end
  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oCapture = cap_q;
  assign oClearAcc = clr_q;
  assign oWeightLoad = wl_q;
  assign oWeightAddr = wa_q;
  assign oDataRd = rd_q;
  assign oDataAddr = da_q;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] bc_q, bc_d;
  always_comb bc_d = accept ? '0 : (busy_q && bc_q != '1) ? bc_q + 1'b1 : bc_q;
  always_ff @(posedge iClk) bc_q <= iRst ? '0 : bc_d;
  assign oBusyCycles = bc_q;
`endif
endmodule
